andor_exerciser: RTL and testbench

//   Drives all 2^N_IN input vectors into a combinational gate network such as the
//   2-level AND-OR (Y = A&B | C&D) and captures its output after a settle delay.
//   It compares each response against a truth-table parameter and reports a

---
 rtl/andor_exerciser.sv | 97 +++++++++
 tb/tb_andor_exerciser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/andor_exerciser.sv
// Exhaustive input sweeper for a small combinational network: drives every vector, waits a
// settle time, samples Y against a truth-table parameter and keeps a pass/fail summary.
module andor_exerciser #(
  parameter int unsigned         N_IN          = 4,
  parameter logic [2**N_IN-1:0]  EXPECTED      = 16'hF888,
  parameter int unsigned         SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StFin} state_e;

  localparam logic [N_IN-1:0] StimMax    = '1;
  localparam logic [3:0]      SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e        state;
  logic [3:0]    settle_cnt;
  logic          mismatch;
  logic [N_IN:0] err_next;

  // Include the current compare so pass can be judged on the final vector's edge.
  always_comb begin
    mismatch = (dut_y != EXPECTED[stim]);
    err_next = err_count + {{N_IN{1'b0}}, mismatch};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      settle_cnt <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          stim <= '0;
          done <= 1'b0;
          if (start) begin
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= '0;
            state      <= StSettle;
          end
        end
        StSettle: begin
          if (settle_cnt == SettleLast) begin
            state <= StSample;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        StSample: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            first_fail <= stim;
            fail_valid <= 1'b1;
          end
          if (stim == StimMax) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == '0);
            state <= StFin;
          end else begin
            stim       <= stim + 1'b1;
            settle_cnt <= '0;
            state      <= StSettle;
          end
        end
        StFin: begin
          done  <= 1'b0;
          stim  <= '0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_andor_exerciser.sv
// Bench for andor_exerciser: directed response tables plus random tables checked against
// a truth-table model of Y = A&B | C&D.
module tb_andor_exerciser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  stim;
  logic        dut_y;
  logic        busy, done, pass, fail_valid;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic [15:0] resp = '0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign dut_y = resp[stim];

  andor_exerciser #(
    .N_IN(4),
    .EXPECTED(16'hF888),
    .SETTLE_CYCLES(2)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stim(stim),
    .dut_y(dut_y),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_fail(first_fail),
    .fail_valid(fail_valid)
  );

  typedef struct {
    string       name;
    logic [15:0] resp;
    int          err;
    int          ff;
    bit          fv;
    bit          pass;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    else passed++;
  endtask

  function automatic bit golden(input int k);
    return (((k >> 3) & 1) == 1 && ((k >> 2) & 1) == 1) || (((k >> 1) & 1) == 1 && (k & 1) == 1);
  endfunction

  function automatic logic [15:0] golden_tbl();
    logic [15:0] t;
    for (int k = 0; k < 16; k++) t[k] = golden(k);
    return t;
  endfunction

  function automatic logic [15:0] ab_only_tbl();
    logic [15:0] t;
    for (int k = 0; k < 16; k++) t[k] = (((k >> 3) & 1) == 1) && (((k >> 2) & 1) == 1);
    return t;
  endfunction

  function automatic void model(input logic [15:0] r, output int err, output int ff, output bit fv);
    err = 0; ff = 0; fv = 0;
    for (int k = 0; k < 16; k++) begin
      if (r[k] != golden(k)) begin
        err++;
        if (!fv) begin ff = k; fv = 1; end
      end
    end
  endfunction

  // Pulses start, follows the sweep edge by edge; repulse_at re-asserts start for that edge.
  task automatic run_sweep(input string tag, input int repulse_at, output int done_edge);
    int stim_bad = 0;
    int busy_bad = 0;
    done_edge = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, " cleared_at_start"}, {err_count, first_fail, fail_valid, pass, busy}, 1);
    for (int n = 1; n <= 200; n++) begin
      if (n == repulse_at) start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      if (done) begin done_edge = n; break; end
      if (stim !== 4'(n / 3)) stim_bad++;
      if (busy !== 1'b1) busy_bad++;
    end
    chk({tag, " done_edge"}, done_edge, 48);
    chk({tag, " stim_sequence_errs"}, stim_bad, 0);
    chk({tag, " busy_errs"}, busy_bad, 0);
    if (done_edge > 0) begin
      chk({tag, " fin_busy_stim"}, {busy, stim}, 15);
      @(posedge clk); #1;
      chk({tag, " done_pulse_end"}, {done, stim}, 0);
    end
  endtask

  task automatic check_results(input string tag, input int err, input int ff, input bit fv,
                               input bit ps);
    chk({tag, " err_count"}, int'(err_count), err);
    chk({tag, " fail_valid"}, int'(fail_valid), int'(fv));
    chk({tag, " pass"}, int'(pass), int'(ps));
    if (fv) chk({tag, " first_fail"}, int'(first_fail), ff);
  endtask

  initial begin
    vec_t tbl[4];
    int   de, e, f, de1, de2, done_seen;
    bit   v;

    tbl[0] = '{"golden",  golden_tbl(),  0,  0, 1'b0, 1'b1};
    tbl[1] = '{"tied0",   16'h0000,      7,  3, 1'b1, 1'b0};
    tbl[2] = '{"ab_only", ab_only_tbl(), 3,  3, 1'b1, 1'b0};
    tbl[3] = '{"inverted", ~golden_tbl(), 16, 0, 1'b1, 1'b0};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {stim, busy, done, pass, err_count, first_fail, fail_valid}, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      resp = tbl[i].resp;
      run_sweep(tbl[i].name, -1, de);
      check_results(tbl[i].name, tbl[i].err, tbl[i].ff, tbl[i].fv, tbl[i].pass);
      repeat (5) @(posedge clk);
      #1;
      chk({tbl[i].name, " held_in_idle"}, {err_count, fail_valid, pass, busy}, {5'(tbl[i].err),
          tbl[i].fv, tbl[i].pass, 1'b0});
    end

    // Restart ignored mid-sweep; previous (inverted) results must clear on the new start edge.
    resp = 16'h0000;
    run_sweep("repulse", 10, de);
    check_results("repulse", 7, 3, 1'b1, 1'b0);

    // Random response tables against the model.
    for (int i = 0; i < 4; i++) begin
      resp = 16'($urandom);
      model(resp, e, f, v);
      run_sweep("random", -1, de);
      check_results("random", e, f, v, (e == 0));
    end

    // Start held high: back-to-back sweeps.
    resp = golden_tbl();
    de1 = -1; de2 = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (de1 < 0) de1 = n;
        else begin de2 = n; break; end
      end
    end
    start = 1'b0;
    chk("held_start first_done", de1, 48);
    chk("held_start second_done", de2, 98);
    check_results("held_start", 0, 0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);

    // Reset mid-sweep at edge 20.
    resp = 16'h0000;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_reset busy_errs", {busy, err_count}, {1'b1, 5'd1});
    rst_n = 1'b0;
    #1;
    chk("async_reset outputs", {stim, busy, done, pass, err_count, first_fail, fail_valid}, 0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("reset no_done", done_seen, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("post_reset stays_idle", done_seen, 0);
    resp = golden_tbl();
    run_sweep("after_reset", -1, de);
    check_results("after_reset", 0, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
